// File: rtl/div_pkg.sv
// Shared types and sizing constants for the sequential restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DIV_WIDTH_DEFAULT     = 8;
    localparam int DIV_CNT_WIDTH_DEFAULT = $clog2(DIV_WIDTH_DEFAULT) + 1;

    // The iteration counter must hold the value WIDTH itself, hence the extra bit.
    function automatic int cntWidth(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/div_sub_stage.sv
// Trial-subtract cell of the restoring divider: (WIDTH+1)-bit difference split into
// the low WIDTH bits and a sign bit that says whether the subtraction underflowed.
module div_sub_stage
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   i_minuend,
    input  logic [WIDTH:0]   i_subtrahend,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_neg
);

    logic [WIDTH:0] w_full;

    assign w_full = i_minuend - i_subtrahend;
    assign o_diff = w_full[WIDTH-1:0];
    assign o_neg  = w_full[WIDTH];

endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_BY_ZERO_TRAP_EN to short-circuit zero divisors straight to DONE with dbz set.
module seq_restoring_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz
);

    localparam int            CW       = cntWidth(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t r_state;
    state_t w_stateNext;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]   w_rShift;
    logic [WIDTH-1:0] w_diff;
    logic             w_neg;
    logic [WIDTH-1:0] w_rNext;
    logic [WIDTH-1:0] w_qNext;
    logic             w_lastIter;

    // The partial remainder stays below the divisor, so WIDTH bits suffice for storage;
    // only the shifted value needs the extra bit for the trial subtraction.
    assign w_rShift = {r_r, r_q[WIDTH-1]};

    div_sub_stage #(
        .WIDTH(WIDTH)
    ) u_sub (
        .i_minuend   (w_rShift),
        .i_subtrahend({1'b0, r_d}),
        .o_diff      (w_diff),
        .o_neg       (w_neg)
    );

    assign w_rNext    = w_neg ? w_rShift[WIDTH-1:0] : w_diff;
    assign w_qNext    = {r_q[WIDTH-2:0], ~w_neg};
    assign w_lastIter = (r_cnt == CNT_ONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
`ifdef DIV_BY_ZERO_TRAP_EN
                    w_stateNext = (num2 == '0) ? DONE : RUN;
`else
                    w_stateNext = RUN;
`endif
                end
            end
            RUN: begin
                busy = 1'b1;
                if (w_lastIter) begin
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

`ifdef DIV_BY_ZERO_TRAP_EN
    logic r_dbz;
`endif

    // Results are written only on the edge that enters DONE and are held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            r_d    <= '0;
            r_r    <= '0;
            r_cnt  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
`ifdef DIV_BY_ZERO_TRAP_EN
            r_dbz  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_q   <= num1;
                        r_d   <= num2;
                        r_r   <= '0;
                        r_cnt <= CNT_INIT;
`ifdef DIV_BY_ZERO_TRAP_EN
                        r_dbz <= (num2 == '0);
                        if (num2 == '0) begin
                            r_quot <= '1;
                            r_rem  <= num1;
                        end
`endif
                    end
                end
                RUN: begin
                    r_q   <= w_qNext;
                    r_r   <= w_rNext;
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_lastIter) begin
                        r_quot <= w_qNext;
                        r_rem  <= w_rNext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign quotient  = r_quot;
    assign remainder = r_rem;

`ifdef DIV_BY_ZERO_TRAP_EN
    assign dbz = r_dbz;
`else
    assign dbz = 1'b0;
`endif

endmodule
